// File: rtl/dma_block_copier_if.sv
// DMA port bundle between a DMA initiator and the MSP430 DMA slave port.
//   dma_addr     : word-aligned byte address (bit0 always 0)
//   dma_en       : transaction request, held until dma_ready
//   dma_we       : 2'b00 read, 2'b11 write
//   dma_din      : write data toward memory
//   dma_dout     : read data from memory, valid the cycle after a read's dma_ready
//   dma_ready    : transaction accepted this cycle
//   dma_resp     : error response, qualified by dma_ready
//   dma_priority : static priority of this initiator
`timescale 1ns/1ps
interface dma_block_copier_if;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic [15:0] dma_din;
  logic [15:0] dma_dout;
  logic        dma_ready;
  logic        dma_resp;
  logic        dma_priority;

  modport master (
    output dma_addr, dma_en, dma_we, dma_din, dma_priority,
    input  dma_dout, dma_ready, dma_resp
  );

  modport slave (
    input  dma_addr, dma_en, dma_we, dma_din, dma_priority,
    output dma_dout, dma_ready, dma_resp
  );
endinterface

// File: rtl/dma_block_copier.sv
// Block copier acting as a DMA initiator: moves cfg_len 16-bit words from
// cfg_src to cfg_dst as alternating read/write transactions.
//   clk, reset_n      : rising-edge clock, asynchronous active-low reset
//   start             : one-cycle pulse, accepted only in IDLE
//   cfg_src/dst/len   : byte addresses (bit0 ignored) and word count
//   abort             : kill request from the access-control monitor
//   busy, done, err   : status (done is a pulse, err is sticky)
//   dma               : master side of the DMA port bundle
`timescale 1ns/1ps
module dma_block_copier #(
  parameter logic [15:0] MAX_LEN  = 16'h0800,
  parameter logic        DMA_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] cfg_src,
  input  logic [15:0] cfg_dst,
  input  logic [15:0] cfg_len,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err,
  dma_block_copier_if.master dma
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN} state_t;

  state_t      state_q;
  logic [15:0] src_q, dst_q, cnt_q;
  logic [15:0] addr_q, din_q;
  logic [1:0]  we_q;
  logic        en_q, busy_q, done_q, err_q;

  // din_q doubles as the data register between the read and the write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 2'b00;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE && abort) begin
        // Abort wins over any handshake seen in the same cycle.
        state_q <= IDLE;
        en_q    <= 1'b0;
        busy_q  <= 1'b0;
        err_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !abort) begin
              if (cfg_len == 16'd0) begin
                state_q <= FIN;
                done_q  <= 1'b1;
                err_q   <= 1'b0;
              end else if (cfg_len > MAX_LEN) begin
                err_q <= 1'b1;
              end else begin
                src_q   <= cfg_src & 16'hFFFE;
                dst_q   <= cfg_dst & 16'hFFFE;
                cnt_q   <= cfg_len;
                err_q   <= 1'b0;
                busy_q  <= 1'b1;
                en_q    <= 1'b1;
                we_q    <= 2'b00;
                addr_q  <= cfg_src & 16'hFFFE;
                state_q <= RD_REQ;
              end
            end
          end
          RD_REQ: begin
            if (dma.dma_ready) begin
              en_q <= 1'b0;
              if (dma.dma_resp) begin
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= RD_WAIT;
              end
            end
          end
          RD_WAIT: begin
            din_q   <= dma.dma_dout;
            en_q    <= 1'b1;
            we_q    <= 2'b11;
            addr_q  <= dst_q;
            state_q <= WR_REQ;
          end
          WR_REQ: begin
            if (dma.dma_ready) begin
              if (dma.dma_resp) begin
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                // Address increments wrap modulo 2^16 by design.
                src_q <= src_q + 16'd2;
                dst_q <= dst_q + 16'd2;
                cnt_q <= cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                  en_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FIN;
                end else begin
                  we_q    <= 2'b00;
                  addr_q  <= src_q + 16'd2;
                  state_q <= RD_REQ;
                end
              end
            end
          end
          FIN: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign dma.dma_addr     = addr_q;
  assign dma.dma_en       = en_q;
  assign dma.dma_we       = we_q;
  assign dma.dma_din      = din_q;
  assign dma.dma_priority = DMA_PRIO;

endmodule
